// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
//
// Integer ALU for the RV32I execute stage. It computes one of ten operations
// on two operands. The combinational result (out) is used in the same cycle.
// A registered copy (out_q) feeds the writeback path.
//
// Operation select, encoded {funct7[5], funct3}:
//   ADD=0000  SLL=0001  SLT=0010  SLTU=0011
//   XOR=0100  SRL=0101  OR=0110   AND=0111
//   SUB=1000  SRA=1101
// Any other op_code drives out to zero.
//
// Shift amounts use the whole unsigned in_b, not only its low five bits.
// A shift of WIDTH or more therefore saturates:
//   - SLL and SRL give 0.
//   - SRA gives copies of the sign bit.
//
// Optional feature (macro ALU_FLAGS_EN):
//   Defining ALU_FLAGS_EN adds three combinational status outputs:
//   zero, neg and ovf (signed overflow for ADD/SUB).
//   With the macro undefined, these ports do not exist.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset; affects out_q only
//   in_a     in   operand A (rs1 / PC)
//   in_b     in   operand B (rs2 / immediate / shift amount)
//   op_code  in   operation select
//   out      out  combinational result
//   out_q    out  result registered on clk; zero after reset
//   zero     out  (ALU_FLAGS_EN) out == 0
//   neg      out  (ALU_FLAGS_EN) out[WIDTH-1]
//   ovf      out  (ALU_FLAGS_EN) signed overflow of ADD/SUB, else 0
// -----------------------------------------------------------------------------
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       op_code,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    // Operation encodings
    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SLL  = 4'b0001;
    localparam logic [3:0] SLT  = 4'b0010;
    localparam logic [3:0] SLTU = 4'b0011;
    localparam logic [3:0] XOR  = 4'b0100;
    localparam logic [3:0] SRL  = 4'b0101;
    localparam logic [3:0] OR   = 4'b0110;
    localparam logic [3:0] AND  = 4'b0111;
    localparam logic [3:0] SUB  = 4'b1000;
    localparam logic [3:0] SRA  = 4'b1101;

    // Number of barrel-shifter stages (5 for a 32-bit datapath)
    localparam int SHW = $clog2(WIDTH);

    // -------------------------------------------------------------------------
    // Shared adder / subtractor
    //
    // SUB, SLT and SLTU all use the same a + ~b + 1 datapath.
    // The comparisons read their answer from that subtraction:
    //   - The carry-out is the inverse of the unsigned borrow.
    //   - The signed compare uses the difference sign.
    //     When the operand signs differ, it uses in_a's sign instead.
    // -------------------------------------------------------------------------
    logic             do_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             sign_differ;
    logic             lt_signed;
    logic             lt_unsigned;

    assign do_sub      = (op_code == SUB) || (op_code == SLT) || (op_code == SLTU);
    assign b_eff       = do_sub ? ~in_b : in_b;
    assign sum_ext     = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, do_sub};
    assign sign_differ = in_a[WIDTH-1] ^ in_b[WIDTH-1];
    assign lt_signed   = sign_differ ? in_a[WIDTH-1] : sum_ext[WIDTH-1];
    assign lt_unsigned = ~sum_ext[WIDTH];

    // -------------------------------------------------------------------------
    // Barrel shifter
    //
    // One right-shifting log shifter serves all three shifts.
    //   - SLL: the operand is bit-reversed on entry.
    //     The result is reversed back on exit.
    //   - SRA: vacated bits are filled with the sign bit.
    //   - SRL and SLL: vacated bits are filled with zero.
    // -------------------------------------------------------------------------
    logic             shift_left;
    logic             fill_bit;
    logic             shift_big;
    logic [WIDTH-1:0] a_rev;
    logic [WIDTH-1:0] shift_src;
    logic [WIDTH-1:0] stage_data [0:SHW];
    logic [WIDTH-1:0] shift_raw;
    logic [WIDTH-1:0] shift_raw_rev;
    logic [WIDTH-1:0] shift_result;

    assign shift_left = (op_code == SLL);
    assign fill_bit   = (op_code == SRA) & in_a[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign a_rev[gi]         = in_a[WIDTH-1-gi];
            assign shift_raw_rev[gi] = shift_raw[WIDTH-1-gi];
        end
    endgenerate

    assign shift_src     = shift_left ? a_rev : in_a;
    assign stage_data[0] = shift_src;

    // Stage gi shifts by 2**gi when bit gi of the amount is set.
    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_shift_stage
            localparam int STEP = 1 << gi;
            assign stage_data[gi+1] = in_b[gi]
                ? {{STEP{fill_bit}}, stage_data[gi][WIDTH-1:STEP]}
                : stage_data[gi];
        end
    endgenerate

    // Any set bit above the stage bits means the amount is at least WIDTH.
    // Every bit has then been shifted out, so only fill remains.
    assign shift_big    = |in_b[WIDTH-1:SHW];
    assign shift_raw    = shift_big ? {WIDTH{fill_bit}} : stage_data[SHW];
    assign shift_result = shift_left ? shift_raw_rev : shift_raw;

    // -------------------------------------------------------------------------
    // Result select
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] alu_result;

    always_comb begin
        alu_result = '0;
        case (op_code)
            ADD, SUB:      alu_result = sum_ext[WIDTH-1:0];
            SLT:           alu_result = {{(WIDTH-1){1'b0}}, lt_signed};
            SLTU:          alu_result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            XOR:           alu_result = in_a ^ in_b;
            OR:            alu_result = in_a | in_b;
            AND:           alu_result = in_a & in_b;
            SLL, SRL, SRA: alu_result = shift_result;
            default:       alu_result = '0;
        endcase
    end

    assign out = alu_result;

    // -------------------------------------------------------------------------
    // Registered copy for writeback. Reset takes priority over the load.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] out_q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q_reg <= '0;
        end else begin
            out_q_reg <= alu_result;
        end
    end

    assign out_q = out_q_reg;

`ifdef ALU_FLAGS_EN
    // -------------------------------------------------------------------------
    // Status flags
    //
    // Signed overflow is reported only for ADD and SUB.
    //   - ADD: both operands have the same sign, and the result sign differs.
    //   - SUB: the operand signs differ, and the result sign differs from in_a.
    // -------------------------------------------------------------------------
    logic add_ovf;
    logic sub_ovf;

    assign add_ovf = ~sign_differ & (alu_result[WIDTH-1] ^ in_a[WIDTH-1]);
    assign sub_ovf =  sign_differ & (alu_result[WIDTH-1] ^ in_a[WIDTH-1]);

    assign zero = (alu_result == '0);
    assign neg  = alu_result[WIDTH-1];
    assign ovf  = (op_code == ADD) ? add_ovf :
                  (op_code == SUB) ? sub_ovf : 1'b0;
`endif

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SLL  = 4'b0001;
    localparam logic [3:0] SLT  = 4'b0010;
    localparam logic [3:0] SLTU = 4'b0011;
    localparam logic [3:0] XOR  = 4'b0100;
    localparam logic [3:0] SRL  = 4'b0101;
    localparam logic [3:0] OR   = 4'b0110;
    localparam logic [3:0] AND  = 4'b0111;
    localparam logic [3:0] SUB  = 4'b1000;
    localparam logic [3:0] SRA  = 4'b1101;

    logic        clk;
    logic        reset;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  op_code;
    logic [31:0] out;
    logic [31:0] out_q;
`ifdef ALU_FLAGS_EN
    logic        zero;
    logic        neg;
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    alu_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_a    (in_a),
        .in_b    (in_b),
        .op_code (op_code),
        .out     (out),
        .out_q   (out_q)
`ifdef ALU_FLAGS_EN
        ,
        .zero    (zero),
        .neg     (neg),
        .ovf     (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    // Reference model: plain arithmetic straight from the operation rules.
    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            ADD:  return 32'(a + b);
            SUB:  return 32'(a - b);
            SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            SLTU: return (a < b) ? 32'd1 : 32'd0;
            XOR:  return a ^ b;
            OR:   return a | b;
            AND:  return a & b;
            SLL:  return (b >= 32) ? 32'd0 : 32'(a << b);
            SRL:  return (b >= 32) ? 32'd0 : 32'(a >> b);
            SRA:  return (b >= 32) ? (sa < 0 ? 32'hFFFF_FFFF : 32'd0)
                                   : 32'(sa >>> b);
            default: return 32'd0;
        endcase
    endfunction

`ifdef ALU_FLAGS_EN
    function automatic logic ref_ovf(input logic [3:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        longint r;
        r = 0;
        if (op == ADD) r = longint'($signed(a)) + longint'($signed(b));
        else if (op == SUB) r = longint'($signed(a)) - longint'($signed(b));
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one operation at the falling edge, then check out 1 ns later.
    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_code = op;
        in_a    = a;
        in_b    = b;
        #1;
    endtask

    task automatic check_flags(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_FLAGS_EN
        logic [31:0] e;
        e = ref_alu(op, a, b);
        check("zero", {31'd0, zero}, {31'd0, e == 32'd0});
        check("neg",  {31'd0, neg},  {31'd0, e[31]});
        check("ovf",  {31'd0, ovf},  {31'd0, ref_ovf(op, a, b)});
`else
        if (op === 4'bxxxx || a === 32'hx || b === 32'hx) begin
            // no flag outputs in this build
        end
`endif
    endtask

    vec_t vecs [20];

    initial begin
        vecs[0]  = '{ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[1]  = '{ADD,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        vecs[2]  = '{SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[3]  = '{SUB,  32'd31,        32'd15,        32'd16};
        vecs[4]  = '{SUB,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
        vecs[5]  = '{SLL,  32'd3,         32'd30,        32'hC000_0000};
        vecs[6]  = '{SLL,  32'd3,         32'd31,        32'h8000_0000};
        vecs[7]  = '{SLL,  32'd3,         32'd32,        32'h0000_0000};
        vecs[8]  = '{SRL,  32'h80F0_01FF, 32'd31,        32'h0000_0001};
        vecs[9]  = '{SRA,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF};
        vecs[10] = '{SRA,  32'd30,        32'd1,         32'd15};
        vecs[11] = '{SLT,  32'hFFFF_FFFF, 32'd0,         32'd1};
        vecs[12] = '{SLT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        vecs[13] = '{SLT,  32'h8000_0000, 32'h8000_0001, 32'd1};
        vecs[14] = '{SLT,  32'd3,         32'd2,         32'd0};
        vecs[15] = '{SLTU, 32'hFFFF_FFFF, 32'd0,         32'd0};
        vecs[16] = '{XOR,  32'h0321_10C0, 32'hAF2E_EFFB, 32'hAC0F_FF3B};
        vecs[17] = '{OR,   32'h0321_10C0, 32'hAF2E_EFFB, 32'hAF2F_FFFB};
        vecs[18] = '{AND,  32'h0321_10C0, 32'hAF2E_EFFB, 32'h0320_00C0};
        vecs[19] = '{4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};

        reset   = 1'b1;
        op_code = ADD;
        in_a    = 32'd0;
        in_b    = 32'd0;

        // Reset state
        @(posedge clk);
        #1;
        check("reset_out_q", out_q, 32'd0);
        $display("txn reset out_q=%h", out_q);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 20; i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            $display("txn vec %0d op=%b a=%h b=%h out=%h exp=%h",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, out, vecs[i].exp);
            check($sformatf("vec%0d", i), out, vecs[i].exp);
        end

        // Register path: load, then reset with inputs held
        apply(ADD, 32'd15, 32'd15);
        @(posedge clk);
        #1;
        check("q_load", out_q, 32'd30);
        $display("txn load out_q=%h", out_q);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("q_reset", out_q, 32'd0);
        check("out_hold", out, 32'd30);
        $display("txn midreset out=%h out_q=%h", out, out_q);
        @(negedge clk);
        reset = 1'b0;

`ifdef ALU_FLAGS_EN
        apply(ADD, 32'h7FFF_FFFF, 32'd1);
        check("ovf_add", {31'd0, ovf},  32'd1);
        check("neg_add", {31'd0, neg},  32'd1);
        check("zero_add", {31'd0, zero}, 32'd0);
        $display("txn flags zero=%b neg=%b ovf=%b", zero, neg, ovf);
`endif

        // Randomized against the reference model, including the registered copy
        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] e;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 40));
                1:       b = a;
                default: b = $urandom;
            endcase
            e = ref_alu(op, a, b);
            apply(op, a, b);
            check($sformatf("rnd%0d_out", i), out, e);
            check_flags(op, a, b);
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d_q", i), out_q, e);
            $display("txn rnd %0d op=%b a=%h b=%h out=%h out_q=%h exp=%h",
                     i, op, a, b, out, out_q, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Integer ALU for the RV32I core datapath.
- Computes one of ten operations on two 32-bit operands.
- `out` is a combinational result, consumed the same cycle by the execute stage.
- `out_q` is a registered copy of the result, used by the writeback path.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is required to be supported.

Ports:
- clk  input  1  clock; rising edge.
- reset  input  1  synchronous, active-high reset.
- in_a  input  32  operand A (rs1 / PC).
- in_b  input  32  operand B (rs2 / immediate / shift amount).
- op_code  input  4  operation select, encoded {funct7[5], funct3}.
- out  output  32  combinational result.
- out_q  output  32  result registered on the rising clk edge.

Behaviour:
- op_code encoding (shared include, names fixed):
  - ADD=4'b0000, SLL=4'b0001, SLT=4'b0010, SLTU=4'b0011
  - XOR=4'b0100, SRL=4'b0101, OR=4'b0110, AND=4'b0111
  - SUB=4'b1000, SRA=4'b1101
- ADD: in_a+in_b mod 2^32; carry dropped. 0xFFFFFFFF+1 = 0; 0x80000000+0xFFFFFFFF = 0x7FFFFFFF.
- SUB: in_a-in_b mod 2^32. 0-1 = 0xFFFFFFFF; 0x80000000-0xFFFFFFFF = 0x80000001.
- SLT: 1 if signed(in_a) < signed(in_b), else 0; upper 31 bits zero.
- SLTU: same as SLT but unsigned compare.
- XOR/OR/AND: bitwise.
- Shift amount is the full unsigned 32-bit in_b, not in_b[4:0]:
  - SLL: in_a << in_b; result 0 when in_b >= 32.
  - SRL: logical right shift; result 0 when in_b >= 32.
  - SRA: arithmetic right shift, sign-filled; result = {32{in_a[31]}} when in_b >= 32.
- Unused op_code values (1001,1010,1011,1100,1110,1111): out = 0.
- out is purely combinational from in_a, in_b, op_code. Zero latency; independent of clk and reset. No X on out for any defined input.
- out_q:
  - On each rising clk edge, out_q <= out.
  - If reset is high at the edge, out_q <= 0 instead.
  - Reset has priority over the load.
  - Reset value 0; 1-cycle latency.
- Reset mid-operation affects only out_q; out keeps tracking the inputs.
- No handshake; a new operation may be presented every cycle.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined, three extra outputs are added, each 1 bit, combinational, valid the same cycle as out:
  - zero: out == 0.
  - neg: out[31].
  - ovf: signed overflow.
    - ADD: operands have the same sign and the result sign differs.
    - SUB: operands have different signs and the result sign differs from in_a.
    - Every other op: 0.
- When not defined, these ports and their logic are absent; everything else is unchanged.

Test Plan:
- ADD/SUB wrap: ADD 0xFFFFFFFF+1 -> out=0. ADD 0x80000000+0xFFFFFFFF -> 0x7FFFFFFF. SUB 0-1 -> 0xFFFFFFFF. SUB 31-15 -> 16.
- Shifts:
  - SLL 3<<30 -> 0xC0000000; 3<<31 -> 0x80000000; 3<<32 -> 0.
  - SRL 0x80F001FF>>31 -> 1.
  - SRA 0x80000000>>>31 -> 0xFFFFFFFF.
  - SRA 30>>>1 -> 15.
- Compares:
  - SLT: -1<0 -> 1; -1<-1 -> 0; 0x80000000<0x80000001 -> 1; 3<2 -> 0.
  - SLTU: 0xFFFFFFFF<0 -> 0.
- Logic, with in_a=0x032110C0, in_b=0xAF2EEFFB: XOR -> 0xAC0FFF3B; OR -> 0xAF2FFFFB; AND -> 0x032000C0.
- Register path: reset=1 for one edge -> out_q=0. Next edge with ADD 15+15 -> out_q=30. Assert reset while inputs are unchanged -> out_q=0 after the edge while out stays 30.
- Undefined op_code 4'b1111 with any operands -> out=0. With ALU_FLAGS_EN: ADD 0x7FFFFFFF+1 -> ovf=1, neg=1, zero=0.
